// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: HI/LO unit op encoding, its FSM states, and the
// SPECIAL funct codes that control/execute decode into op, hi_we and lo_we.
package mips_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } md_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // The funct low bit means "unsigned", the op low bit means "signed".
    function automatic logic [1:0] funct_to_op(input logic [5:0] funct);
        logic [1:0] r;
        r = 2'b00;
        case (funct)
            FUNCT_MULT:  r = OP_MULT;
            FUNCT_MULTU: r = OP_MULTU;
            FUNCT_DIV:   r = OP_DIV;
            FUNCT_DIVU:  r = OP_DIVU;
            default:     r = OP_MULTU;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, sharing a single WIDTH+1-bit adder/subtractor.
module mult_div
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic s);
        return s ? neg_w(x) : x;
    endfunction

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   add_a, add_b, add_y;
    logic [2*WIDTH-1:0] prod_fix;

    assign sign_a = op[0] & operand_a[WIDTH-1];
    assign sign_b = op[0] & operand_b[WIDTH-1];
    assign mag_a  = abs_w(operand_a, sign_a);
    assign mag_b  = abs_w(operand_b, sign_b);

    // Shared adder: multiply adds the multiplicand into the upper half,
    // divide subtracts the divisor from the shifted partial remainder.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign add_a = is_div_q ? div_shift : {1'b0, acc_hi_q};
    assign add_b = is_div_q ? ~{1'b0, opnd_q}
                            : {1'b0, (acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign add_y = add_a + add_b + {{WIDTH{1'b0}}, is_div_q};

    assign prod_fix = neg_res_q ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CALC;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    is_div_d  = op[1];
                    acc_hi_d  = '0;
                    acc_lo_d  = op[1] ? mag_a : mag_b;
                    opnd_d    = op[1] ? mag_b : mag_a;
                    // Divide by zero leaves the all-ones quotient unsigned; the
                    // remainder fix-up then restores the raw dividend.
                    neg_res_d = (sign_a ^ sign_b) & ~(op[1] & (operand_b == '0));
                    neg_rem_d = sign_a;
                end else begin
                    if (hi_we) hi_d = write_data;
                    if (lo_we) lo_d = write_data;
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    if (!add_y[WIDTH]) begin
                        acc_hi_d = add_y[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {acc_hi_d, acc_lo_d} = {add_y, acc_lo_q[WIDTH-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_LAST) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (is_div_q) begin
                    hi_d = neg_rem_q ? neg_w(acc_hi_q) : acc_hi_q;
                    lo_d = neg_res_q ? neg_w(acc_lo_q) : acc_lo_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
